// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   owner_t      : owner of the read currently returning data from the SRAM
//   MAX_WAIT_DEF : default number of consecutive lost cycles before A is forced to win
//   CNT_W        : width of the saturating conflict counter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam int MAX_WAIT_DEF = 4;
    localparam int CNT_W        = 16;

endpackage

// File: rtl/sram_port_arbiter_starve_counter.sv
// starve_counter: counts consecutive cycles in which requester A was pending
// but lost arbitration. Saturates at MAX_WAIT; o_at_max tells the arbiter
// that A must win this cycle.
//   clk      in  clock, rising edge
//   i_rst_n  in  synchronous active-low reset
//   i_clr    in  clear (A granted or A not requesting); has priority over i_inc
//   i_inc    in  A pending and lost this cycle
//   o_at_max out count has reached MAX_WAIT
module starve_counter
    import sram_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_max
);

    localparam int W = $clog2(MAX_WAIT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != W'(MAX_WAIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == W'(MAX_WAIT));

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 1RW SRAM port between requester A
// (Wishbone side, read/write) and requester B (real-time pattern fetch,
// read-only). B wins by default; after MAX_WAIT consecutive lost cycles A is
// forced to win. Grants are combinational (0-cycle), read data returns one
// cycle after the grant.
//   io_wbs_clk / io_wbs_rst_n          clock, synchronous active-low reset
//   a_req/a_we/a_wmask/a_addr/a_wdata  A request fields, held until a_gnt
//   a_gnt/a_rvalid/a_rdata             A grant and read return
//   b_en/b_req/b_addr                  B request (b_en=0 masks b_req)
//   b_gnt/b_rvalid/b_rdata             B grant and read return
//   csb/web/wmask/addr/din/dout        SRAM macro port
//   conflict_cnt                       saturating count of contended cycles
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MASK_W   = 4,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              io_wbs_clk,
    input  logic              io_wbs_rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [MASK_W-1:0] a_wmask,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              csb,
    output logic              web,
    output logic [MASK_W-1:0] wmask,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic              w_bq;
    logic              w_at_max;
    logic              w_a_win;
    logic              w_b_win;
    logic [MASK_W-1:0] w_wmask;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_a_rvalid;
    logic              w_b_rvalid;

    logic [MASK_W-1:0] r_wmask;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    owner_t            r_inflight;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic [CNT_W-1:0]  r_conflict_cnt;

    assign w_bq = b_req & b_en;

    // Grants are suppressed while reset is low so the SRAM sees no access
    // even if requesters keep their request lines up during reset.
    assign w_a_win = io_wbs_rst_n & a_req & (~w_bq | w_at_max);
    assign w_b_win = io_wbs_rst_n & w_bq & ~w_a_win;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (io_wbs_clk),
        .i_rst_n  (io_wbs_rst_n),
        .i_clr    (~a_req | w_a_win),
        .i_inc    (a_req & ~w_a_win),
        .o_at_max (w_at_max)
    );

    // SRAM data-path outputs keep their last driven value on idle cycles
    // to avoid needless toggling on the macro pins.
    always_comb begin
        w_wmask = r_wmask;
        w_addr  = r_addr;
        w_din   = r_din;
        if (!io_wbs_rst_n) begin
            w_wmask = '0;
            w_addr  = '0;
            w_din   = '0;
        end else if (w_a_win) begin
            w_wmask = a_wmask;
            w_addr  = a_addr;
            w_din   = a_wdata;
        end else if (w_b_win) begin
            w_wmask = '0;
            w_addr  = b_addr;
            w_din   = '0;
        end
    end

    always_ff @(posedge io_wbs_clk) begin
        if (!io_wbs_rst_n) begin
            r_wmask        <= '0;
            r_addr         <= '0;
            r_din          <= '0;
            r_inflight     <= OWN_NONE;
            r_a_rdata      <= '0;
            r_b_rdata      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            r_wmask <= w_wmask;
            r_addr  <= w_addr;
            r_din   <= w_din;
            if (w_a_win && !a_we) begin
                r_inflight <= OWN_A;
            end else if (w_b_win) begin
                r_inflight <= OWN_B;
            end else begin
                r_inflight <= OWN_NONE;
            end
            // Capture returning data so each rdata holds until its owner's next read.
            if (r_inflight == OWN_A) begin
                r_a_rdata <= dout;
            end
            if (r_inflight == OWN_B) begin
                r_b_rdata <= dout;
            end
            if (a_req && w_bq && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    // In the rvalid cycle rdata is passed straight from dout; afterwards the
    // captured copy holds it. Outputs read as reset values while reset is low,
    // which also drops a read that was in flight when reset arrived.
    assign w_a_rvalid = io_wbs_rst_n & (r_inflight == OWN_A);
    assign w_b_rvalid = io_wbs_rst_n & (r_inflight == OWN_B);

    assign a_gnt        = w_a_win;
    assign b_gnt        = w_b_win;
    assign a_rvalid     = w_a_rvalid;
    assign b_rvalid     = w_b_rvalid;
    assign a_rdata      = !io_wbs_rst_n ? '0 : (w_a_rvalid ? dout : r_a_rdata);
    assign b_rdata      = !io_wbs_rst_n ? '0 : (w_b_rvalid ? dout : r_b_rdata);
    assign csb          = ~(w_a_win | w_b_win);
    assign web          = ~(w_a_win & a_we);
    assign wmask        = w_wmask;
    assign addr         = w_addr;
    assign din          = w_din;
    assign conflict_cnt = io_wbs_rst_n ? r_conflict_cnt : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter with a behavioural 1RW SRAM model.
// Stimulus pushes expected grants and read data into queues; a monitor
// on the falling clock edge pops and compares whenever the DUT presents
// a grant or an rvalid.
module tb_sram_port_arbiter;

    localparam logic [1:0] G_N = 2'b00;
    localparam logic [1:0] G_A = 2'b10;
    localparam logic [1:0] G_B = 2'b01;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [3:0]  a_wmask;
    logic [8:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_en, b_req, b_gnt, b_rvalid;
    logic [8:0]  b_addr;
    logic [31:0] b_rdata;
    logic        csb, web;
    logic [3:0]  wmask;
    logic [8:0]  addr;
    logic [31:0] din, dout;
    logic [15:0] conflict_cnt;

    logic [31:0] mem [0:511];

    logic [1:0]  q_gnt[$];
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter dut (
        .io_wbs_clk   (clk),
        .io_wbs_rst_n (rst_n),
        .a_req        (a_req),
        .a_we         (a_we),
        .a_wmask      (a_wmask),
        .a_addr       (a_addr),
        .a_wdata      (a_wdata),
        .a_gnt        (a_gnt),
        .a_rvalid     (a_rvalid),
        .a_rdata      (a_rdata),
        .b_en         (b_en),
        .b_req        (b_req),
        .b_addr       (b_addr),
        .b_gnt        (b_gnt),
        .b_rvalid     (b_rvalid),
        .b_rdata      (b_rdata),
        .csb          (csb),
        .web          (web),
        .wmask        (wmask),
        .addr         (addr),
        .din          (din),
        .dout         (dout),
        .conflict_cnt (conflict_cnt)
    );

    // SRAM model: preloads word = addr*3 while reset is low; read data
    // appears on dout the cycle after the access.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'(i * 3);
        end else if (!csb) begin
            if (!web) begin
                for (int k = 0; k < 4; k++)
                    if (wmask[k]) mem[addr][k*8 +: 8] <= din[k*8 +: 8];
            end else begin
                dout <= mem[addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h at %0t", name, act, $time);
        end
    endtask

    // Monitor: compares grants and read returns as the DUT presents them.
    always @(negedge clk) begin
        if (a_gnt | b_gnt) begin
            if (q_gnt.size() == 0) check("unexpected_gnt", 32'({a_gnt, b_gnt}), 32'd0);
            else                   check("gnt", 32'({a_gnt, b_gnt}), 32'(q_gnt.pop_front()));
        end
        if (a_rvalid) begin
            if (q_a.size() == 0) check("unexpected_a_rvalid", a_rdata, 32'hFFFF_FFFF);
            else                 check("a_rdata", a_rdata, q_a.pop_front());
        end
        if (b_rvalid) begin
            if (q_b.size() == 0) check("unexpected_b_rvalid", b_rdata, 32'hFFFF_FFFF);
            else                 check("b_rdata", b_rdata, q_b.pop_front());
        end
    end

    // One cycle of stimulus: drive inputs, queue expected grant/read data,
    // check the SRAM controls on the falling edge, advance to next cycle.
    task automatic cyc(input logic ar, input logic awe, input logic [8:0] aa,
                       input logic [31:0] awd, input logic [3:0] am,
                       input logic br, input logic be, input logic [8:0] ba,
                       input logic [1:0] eg, input logic [31:0] ed, input logic erv);
        a_req = ar; a_we = awe; a_addr = aa; a_wdata = awd; a_wmask = am;
        b_req = br; b_en = be; b_addr = ba;
        if (eg != G_N) q_gnt.push_back(eg);
        if (erv) begin
            if (eg == G_A) q_a.push_back(ed);
            else           q_b.push_back(ed);
        end
        @(negedge clk);
        check("csb", 32'(csb), 32'(eg == G_N));
        if (eg == G_A) begin
            check("web_a", 32'(web), 32'(!awe));
            check("addr_a", 32'(addr), 32'(aa));
        end
        if (eg == G_B) begin
            check("web_b", 32'(web), 32'd1);
            check("addr_b", 32'(addr), 32'(ba));
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 1'b0, 9'h0, G_N, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset with both requesters asserted
        rst_n = 1'b0; a_req = 1'b1; a_we = 1'b0; a_wmask = 4'h0; a_addr = 9'h0;
        a_wdata = 32'h0; b_en = 1'b1; b_req = 1'b1; b_addr = 9'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csb", 32'(csb), 32'd1);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);
        check("rst_gnts", 32'({a_gnt, b_gnt}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 9'h1FF, 32'h0, 4'h0, 1'b1, 1'b1, 9'h000, G_B, 32'h0, 1'b1);
        idle();

        // 4. Back-to-back B reads of 0..7
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 1'b1, 9'(i), G_B, 32'(i * 3), 1'b1);
        idle();

        // 2. A write then read, plus a partial-mask write
        cyc(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 9'h0, G_A, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 9'h005, 32'h0, 4'hF, 1'b0, 1'b1, 9'h0, G_A, 32'hDEADBEEF, 1'b1);
        cyc(1'b1, 1'b1, 9'h005, 32'h11112222, 4'h3, 1'b0, 1'b1, 9'h0, G_A, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 9'h005, 32'h0, 4'hF, 1'b0, 1'b1, 9'h0, G_A, 32'hDEAD2222, 1'b1);
        idle();

        // 3. Contention for 12 cycles after a fresh reset
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [1:0] eg;
            eg = (k == 4 || k == 9) ? G_A : G_B;
            cyc(1'b1, 1'b1, 9'h100, 32'(k), 4'hF, 1'b1, 1'b1, 9'h020, eg, 32'h60, eg == G_B);
        end
        idle();
        check("conflict_cnt", 32'(conflict_cnt), 32'd12);

        // 5. b_en masks B; raising b_en grants B same cycle; in-flight B still returns
        cyc(1'b1, 1'b0, 9'h010, 32'h0, 4'hF, 1'b1, 1'b0, 9'h007, G_A, 32'h30, 1'b1);
        cyc(1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, 1'b0, 9'h007, G_N, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, 1'b1, 9'h007, G_B, 32'd21, 1'b1);
        cyc(1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, 1'b1, 9'h003, G_B, 32'd9, 1'b1);
        cyc(1'b1, 1'b0, 9'h010, 32'h0, 4'hF, 1'b1, 1'b0, 9'h003, G_A, 32'h30, 1'b1);
        idle();

        // 6. Reset the cycle after a B read grant drops the return
        cyc(1'b0, 1'b0, 9'h000, 32'h0, 4'h0, 1'b1, 1'b1, 9'h002, G_B, 32'h0, 1'b0);
        rst_n = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("rst6_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst6_csb", 32'(csb), 32'd1);
        check("rst6_web", 32'(web), 32'd1);
        check("rst6_addr", 32'(addr), 32'd0);
        check("rst6_wmask", 32'(wmask), 32'd0);
        check("rst6_din", din, 32'd0);
        check("rst6_b_rdata", b_rdata, 32'd0);
        check("rst6_a_rdata", a_rdata, 32'd0);
        check("rst6_conflict", 32'(conflict_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_b_rvalid", 32'(b_rvalid), 32'd0);
        @(posedge clk); #1;

        check("q_gnt_empty", 32'(q_gnt.size()), 32'd0);
        check("q_a_empty", 32'(q_a.size()), 32'd0);
        check("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
